// File: rtl/saturn_bus_ctrl_pkg.sv
// Shared types and decode helpers for the saturn memory-bus controller.
package saturn_bus_pkg;

    // Width of the per-region wait-state field and the wait counter.
    localparam int WAIT_W = 4;
    // Decode helpers work on a fixed, generous width so any ADDR_W / N_REG fits.
    localparam int DEC_AW = 32;
    localparam int DEC_NR = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] idx;
    } hit_t;

    // True when addr falls in [base, limit).
    function automatic logic region_hit(input logic [DEC_AW-1:0] addr,
                                        input logic [DEC_AW-1:0] base,
                                        input logic [DEC_AW-1:0] limit);
        return (addr >= base) && (addr < limit);
    endfunction

    // Priority pick: the lowest set bit wins so overlapping regions resolve to the lower index.
    function automatic hit_t first_hit(input logic [DEC_NR-1:0] hit_vec);
        hit_t r;
        logic take;
        r.valid = 1'b0;
        r.idx   = 5'd0;
        for (int i = 0; i < DEC_NR; i++) begin
            take    = hit_vec[i] & ~r.valid;
            r.idx   = take ? 5'(i) : r.idx;
            r.valid = r.valid | take;
        end
        return r;
    endfunction

endpackage

// File: rtl/saturn_bus_ctrl_sync_fifo.sv
// Small synchronous FIFO holding shadowed display-window writes.
module saturn_sync_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 4
) (
    input  logic                     clk_in,
    input  logic                     reset_n_in,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             r_empty;
    logic             r_full;

    logic             w_do_push;
    logic             w_do_pop;
    logic [PW:0]      w_count_nxt;

    // Qualify push/pop (a push into a full FIFO is legal only alongside a pop) and derive next count.
    always_comb begin
        w_do_pop  = i_pop & ~r_empty;
        w_do_push = i_push & (~r_full | w_do_pop);
        if (w_do_push & ~w_do_pop) begin
            w_count_nxt = r_count + (PW+1)'(1'b1);
        end else if (~w_do_push & w_do_pop) begin
            w_count_nxt = r_count - (PW+1)'(1'b1);
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Storage, pointers and registered status flags.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1'b1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1'b1);
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == FULL_CNT);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/saturn_bus_ctrl.sv
// Region-decoding bus controller: programmable wait states, real ack handshake,
// and a display-write shadow FIFO that stalls the CPU when full.
module saturn_bus_ctrl
    import saturn_bus_pkg::*;
#(
    parameter int                         ADDR_W     = 20,
    parameter int                         DATA_W     = 16,
    parameter int                         N_REG      = 4,
    parameter logic [N_REG*ADDR_W-1:0]    REG_BASE   = '0,
    parameter logic [N_REG*ADDR_W-1:0]    REG_LIMIT  = '0,
    parameter logic [N_REG*WAIT_W-1:0]    REG_WAIT   = '0,
    parameter logic [N_REG-1:0]           REG_INT    = '0,
    parameter logic [N_REG-1:0]           REG_DISP   = '0,
    parameter int                         DISP_DEPTH = 4
) (
    input  logic              clk_in,
    input  logic              reset_n_in,
    input  logic [ADDR_W-1:0] cpu_addr_in,
    input  logic              cpu_req_in,
    input  logic              cpu_we_in,
    input  logic [DATA_W-1:0] cpu_data_in,
    output logic [DATA_W-1:0] cpu_data_o,
    output logic              cpu_ack_o,
    output logic              cpu_err_o,
    input  logic [DATA_W-1:0] int_data_in,
    output logic [ADDR_W-1:0] ext_addr_o,
    output logic              ext_oe_n_o,
    output logic              ext_we_n_o,
    output logic [DATA_W-1:0] ext_data_o,
    output logic              ext_data_oe_o,
    input  logic [DATA_W-1:0] ext_data_in,
    output logic              disp_valid_o,
    input  logic              disp_ready_in,
    output logic [9:0]        disp_addr_o,
    output logic [DATA_W-1:0] disp_data_o
);
    localparam int CNT_W = $clog2(DISP_DEPTH) + 1;

    state_e              r_state;
    logic                r_we;
    logic                r_int;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [DATA_W-1:0]   r_cpu_data;
    logic [DATA_W-1:0]   r_ext_data;
    logic [ADDR_W-1:0]   r_ext_addr;
    logic                r_ack;
    logic                r_err;
    logic                r_oe_n;
    logic                r_we_n;
    logic                r_data_oe;

    logic [DEC_NR-1:0]   w_hit_vec;
    hit_t                w_hit;
    logic [N_REG-1:0]    w_sel;
    logic [WAIT_W-1:0]   w_wait;
    logic [ADDR_W-1:0]   w_base;
    logic                w_is_int;
    logic                w_is_disp;
    logic [9:0]          w_disp_off;
    logic                w_disp_wr;
    logic                w_pop;
    logic                w_stall;
    logic                w_accept;
    logic                w_push;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [CNT_W-1:0]    w_fifo_count;
    logic [9+DATA_W:0]   w_fifo_head;

    // Address decode: priority-resolved region and its attributes.
    always_comb begin
        w_hit_vec = '0;
        for (int i = 0; i < N_REG; i++) begin
            w_hit_vec[i] = region_hit(DEC_AW'(cpu_addr_in),
                                      DEC_AW'(REG_BASE[i*ADDR_W +: ADDR_W]),
                                      DEC_AW'(REG_LIMIT[i*ADDR_W +: ADDR_W]));
        end
        w_hit     = first_hit(w_hit_vec);
        w_sel     = '0;
        w_wait    = '0;
        w_base    = '0;
        w_is_int  = 1'b0;
        w_is_disp = 1'b0;
        for (int i = 0; i < N_REG; i++) begin
            w_sel[i]   = w_hit.valid & (w_hit.idx == 5'(i));
            w_wait    |= {WAIT_W{w_sel[i]}} & REG_WAIT[i*WAIT_W +: WAIT_W];
            w_base    |= {ADDR_W{w_sel[i]}} & REG_BASE[i*ADDR_W +: ADDR_W];
            w_is_int  |= w_sel[i] & REG_INT[i];
            w_is_disp |= w_sel[i] & REG_DISP[i];
        end
        w_disp_off = 10'((cpu_addr_in - w_base) >> 2);
    end

    // Request acceptance: a display write into a full FIFO stalls unless the head pops this cycle.
    always_comb begin
        w_pop     = ~w_fifo_empty & disp_ready_in;
        w_disp_wr = (r_state == ST_IDLE) & cpu_req_in & cpu_we_in & w_is_disp;
        w_stall   = w_disp_wr & w_fifo_full & ~w_pop;
        w_accept  = (r_state == ST_IDLE) & cpu_req_in & ~w_stall;
        w_push    = w_disp_wr & ~w_stall;
    end

    // Access sequencer: latch on accept, count wait states, sample read data, pulse ack.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state    <= ST_IDLE;
            r_we       <= 1'b0;
            r_int      <= 1'b0;
            r_wait_cnt <= '0;
            r_cpu_data <= '0;
            r_ext_data <= '0;
            r_ext_addr <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_oe_n     <= 1'b1;
            r_we_n     <= 1'b1;
            r_data_oe  <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_ext_addr <= cpu_addr_in;
                        r_we       <= cpu_we_in;
                        r_int      <= w_is_int;
                        r_wait_cnt <= w_wait;
                        if (cpu_we_in) begin
                            r_ext_data <= cpu_data_in;
                        end
                        if (!w_hit.valid) begin
                            // Unmapped: skip the bus entirely and flag the error.
                            r_state <= ST_ACK;
                            r_ack   <= 1'b1;
                            r_err   <= 1'b1;
                            if (!cpu_we_in) begin
                                r_cpu_data <= '1;
                            end
                        end else begin
                            r_state <= ST_ACCESS;
                            if (!w_is_int) begin
                                r_oe_n    <= cpu_we_in;
                                r_we_n    <= ~cpu_we_in;
                                r_data_oe <= cpu_we_in;
                            end
                        end
                    end
                end
                ST_ACCESS: begin
                    if (r_wait_cnt == '0) begin
                        r_state   <= ST_ACK;
                        r_ack     <= 1'b1;
                        r_oe_n    <= 1'b1;
                        r_we_n    <= 1'b1;
                        r_data_oe <= 1'b0;
                        if (!r_we) begin
                            r_cpu_data <= r_int ? int_data_in : ext_data_in;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'(1'b1);
                    end
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_oe_n    <= 1'b1;
                    r_we_n    <= 1'b1;
                    r_data_oe <= 1'b0;
                end
            endcase
        end
    end

    saturn_sync_fifo #(
        .WIDTH (10 + DATA_W),
        .DEPTH (DISP_DEPTH)
    ) u_disp_fifo (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .i_push     (w_push),
        .i_data     ({w_disp_off, cpu_data_in}),
        .i_pop      (w_pop),
        .o_data     (w_fifo_head),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_count    (w_fifo_count)
    );

    assign cpu_data_o    = r_cpu_data;
    assign cpu_ack_o     = r_ack;
    assign cpu_err_o     = r_err;
    assign ext_addr_o    = r_ext_addr;
    assign ext_oe_n_o    = r_oe_n;
    assign ext_we_n_o    = r_we_n;
    assign ext_data_o    = r_ext_data;
    assign ext_data_oe_o = r_data_oe;
    assign disp_valid_o  = (w_fifo_count != '0);
    assign disp_addr_o   = w_fifo_head[DATA_W +: 10];
    assign disp_data_o   = w_fifo_head[DATA_W-1:0];

endmodule

// File: tb/tb_saturn_bus_ctrl.sv
// Self-checking bench for saturn_bus_ctrl: directed scenarios plus randomized accesses
// checked against a region-table reference model and a display-FIFO queue model.
module tb_saturn_bus_ctrl;

    localparam logic [79:0] P_BASE  = {20'h38000, 20'h2E100, 20'h30000, 20'h00000};
    localparam logic [79:0] P_LIMIT = {20'h50000, 20'h2E160, 20'h40000, 20'h20000};
    localparam logic [15:0] P_WAIT  = {4'd2, 4'd1, 4'd3, 4'd0};
    localparam logic [3:0]  P_INT   = 4'b0001;
    localparam logic [3:0]  P_DISP  = 4'b0100;

    // Reference region table (same map, written as plain numbers).
    int unsigned m_base  [4] = '{32'h00000, 32'h30000, 32'h2E100, 32'h38000};
    int unsigned m_limit [4] = '{32'h20000, 32'h40000, 32'h2E160, 32'h50000};
    int          m_wait  [4] = '{0, 3, 1, 2};
    bit          m_int   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    bit          m_disp  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    logic        clk_in = 1'b0;
    logic        reset_n_in;
    logic [19:0] cpu_addr_in;
    logic        cpu_req_in;
    logic        cpu_we_in;
    logic [15:0] cpu_data_in;
    logic [15:0] cpu_data_o;
    logic        cpu_ack_o;
    logic        cpu_err_o;
    logic [15:0] int_data_in;
    logic [19:0] ext_addr_o;
    logic        ext_oe_n_o;
    logic        ext_we_n_o;
    logic [15:0] ext_data_o;
    logic        ext_data_oe_o;
    logic [15:0] ext_data_in;
    logic        disp_valid_o;
    logic        disp_ready_in;
    logic [9:0]  disp_addr_o;
    logic [15:0] disp_data_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_pops = 0;
    logic [25:0] mq[$];
    logic [15:0] last_rd;

    saturn_bus_ctrl #(
        .ADDR_W(20), .DATA_W(16), .N_REG(4),
        .REG_BASE(P_BASE), .REG_LIMIT(P_LIMIT), .REG_WAIT(P_WAIT),
        .REG_INT(P_INT), .REG_DISP(P_DISP), .DISP_DEPTH(4)
    ) dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in),
        .cpu_addr_in(cpu_addr_in), .cpu_req_in(cpu_req_in), .cpu_we_in(cpu_we_in),
        .cpu_data_in(cpu_data_in), .cpu_data_o(cpu_data_o), .cpu_ack_o(cpu_ack_o),
        .cpu_err_o(cpu_err_o), .int_data_in(int_data_in), .ext_addr_o(ext_addr_o),
        .ext_oe_n_o(ext_oe_n_o), .ext_we_n_o(ext_we_n_o), .ext_data_o(ext_data_o),
        .ext_data_oe_o(ext_data_oe_o), .ext_data_in(ext_data_in),
        .disp_valid_o(disp_valid_o), .disp_ready_in(disp_ready_in),
        .disp_addr_o(disp_addr_o), .disp_data_o(disp_data_o)
    );

    always #5 clk_in = ~clk_in;

    // Display consumer: every pop must deliver the oldest modelled entry.
    always @(negedge clk_in) begin
        if (reset_n_in && disp_valid_o && disp_ready_in) begin
            n_cmp++;
            if (mq.size() == 0) begin
                n_bad++;
                $display("FAIL disp_pop_empty: got %h want no entry", {disp_addr_o, disp_data_o});
            end else begin
                if ({disp_addr_o, disp_data_o} !== mq[0]) begin
                    n_bad++;
                    $display("FAIL disp_head: got %h want %h", {disp_addr_o, disp_data_o}, mq[0]);
                end
                void'(mq.pop_front());
            end
            n_pops++;
        end
    end

    function automatic int model_region(input int unsigned a);
        for (int i = 0; i < 4; i++) begin
            if (a >= m_base[i] && a < m_limit[i]) return i;
        end
        return -1;
    endfunction

    // One CPU access from an idle bus; returns what was observed, cycle 1 = first edge after req.
    task automatic run_access(input logic [19:0] a, input logic w, input logic [15:0] d,
                              output int lat, output int oe_cnt, output int we_cnt,
                              output int doe_cnt, output int bad_wr,
                              output logic [15:0] rd, output logic er, output logic [19:0] ea);
        lat = 0; oe_cnt = 0; we_cnt = 0; doe_cnt = 0; bad_wr = 0; rd = '0; er = 1'b0; ea = '0;
        @(posedge clk_in); #1;
        cpu_addr_in = a; cpu_we_in = w; cpu_data_in = d; cpu_req_in = 1'b1;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(posedge clk_in); #1;
            if (c == 1) ea = ext_addr_o;
            if (!ext_oe_n_o) oe_cnt++;
            if (ext_data_oe_o) doe_cnt++;
            if (!ext_we_n_o) begin
                we_cnt++;
                if (!ext_data_oe_o || ext_data_o !== d) bad_wr++;
            end
            if (cpu_ack_o) begin
                lat = c; rd = cpu_data_o; er = cpu_err_o;
            end
        end
        cpu_req_in = 1'b0;
    endtask

    task automatic test_reset();
        reset_n_in = 1'b0; cpu_req_in = 1'b0; cpu_we_in = 1'b0; cpu_addr_in = '0;
        cpu_data_in = '0; int_data_in = '0; ext_data_in = '0; disp_ready_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        n_cmp++;
        if ({cpu_ack_o, cpu_err_o, cpu_data_o, ext_oe_n_o, ext_we_n_o, ext_data_oe_o,
             ext_addr_o, ext_data_o, disp_valid_o} !== {1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 20'h0, 16'h0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_state: got ack=%b err=%b d=%h oe=%b we=%b doe=%b a=%h ed=%h v=%b want 0 0 0000 1 1 0 00000 0000 0",
                     cpu_ack_o, cpu_err_o, cpu_data_o, ext_oe_n_o, ext_we_n_o, ext_data_oe_o, ext_addr_o, ext_data_o, disp_valid_o);
        end
        reset_n_in = 1'b1;
        last_rd = 16'h0;
    endtask

    task automatic test_int_read();
        int lat, oe, we, doe, bw; logic [15:0] rd; logic er; logic [19:0] ea;
        int_data_in = 16'hA5C3; ext_data_in = 16'h0F0F;
        run_access(20'h00004, 1'b0, 16'h0, lat, oe, we, doe, bw, rd, er, ea);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL int_lat: got %0d want 2", lat); end
        n_cmp++; if (rd !== 16'hA5C3) begin n_bad++; $display("FAIL int_data: got %h want a5c3", rd); end
        n_cmp++; if (oe + we + doe !== 0) begin n_bad++; $display("FAIL int_strobes: got %0d want 0", oe + we + doe); end
        last_rd = 16'hA5C3;
    endtask

    task automatic test_ext_read();
        int lat, oe, we, doe, bw; logic [15:0] rd; logic er; logic [19:0] ea;
        ext_data_in = 16'h1234;
        run_access(20'h30010, 1'b0, 16'h0, lat, oe, we, doe, bw, rd, er, ea);
        n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL ext_rd_lat: got %0d want 5", lat); end
        n_cmp++; if (oe !== 4) begin n_bad++; $display("FAIL ext_rd_oe_cycles: got %0d want 4", oe); end
        n_cmp++; if (rd !== 16'h1234) begin n_bad++; $display("FAIL ext_rd_data: got %h want 1234", rd); end
        n_cmp++; if (ea !== 20'h30010) begin n_bad++; $display("FAIL ext_rd_addr: got %h want 30010", ea); end
        last_rd = 16'h1234;
    endtask

    task automatic test_ext_write();
        int lat, oe, we, doe, bw; logic [15:0] rd; logic er; logic [19:0] ea;
        run_access(20'h30020, 1'b1, 16'hBEEF, lat, oe, we, doe, bw, rd, er, ea);
        n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL ext_wr_lat: got %0d want 5", lat); end
        n_cmp++; if ({we, doe, oe, bw} !== {32'd4, 32'd4, 32'd0, 32'd0}) begin
            n_bad++; $display("FAIL ext_wr_strobes: got we=%0d doe=%0d oe=%0d bad=%0d want 4 4 0 0", we, doe, oe, bw); end
        n_cmp++; if (cpu_data_o !== last_rd) begin n_bad++; $display("FAIL ext_wr_keeps_rdata: got %h want %h", cpu_data_o, last_rd); end
    endtask

    task automatic test_unmapped();
        int lat, oe, we, doe, bw; logic [15:0] rd; logic er; logic [19:0] ea;
        run_access(20'hF0000, 1'b0, 16'h0, lat, oe, we, doe, bw, rd, er, ea);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL unm_lat: got %0d want 1", lat); end
        n_cmp++; if ({er, rd} !== {1'b1, 16'hFFFF}) begin n_bad++; $display("FAIL unm_err_data: got %b %h want 1 ffff", er, rd); end
        n_cmp++; if (oe + we + doe !== 0) begin n_bad++; $display("FAIL unm_strobes: got %0d want 0", oe + we + doe); end
        last_rd = 16'hFFFF;
    endtask

    task automatic test_disp_backpressure();
        int lat, oe, we, doe, bw; logic [15:0] rd; logic er; logic [19:0] ea;
        logic [15:0] dv [5];
        int stall_bad, pops0;
        disp_ready_in = 1'b0;
        for (int k = 0; k < 5; k++) dv[k] = 16'($urandom);
        for (int k = 0; k < 4; k++) begin
            mq.push_back({10'(k), dv[k]});
            run_access(20'h2E100 + 20'(4*k), 1'b1, dv[k], lat, oe, we, doe, bw, rd, er, ea);
            n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL disp_wr_lat[%0d]: got %0d want 3", k, lat); end
            n_cmp++; if ({disp_valid_o, disp_addr_o, disp_data_o} !== {1'b1, 10'd0, dv[0]}) begin
                n_bad++; $display("FAIL disp_head0[%0d]: got %b %h %h want 1 000 %h", k, disp_valid_o, disp_addr_o, disp_data_o, dv[0]); end
        end
        @(posedge clk_in); #1;
        cpu_addr_in = 20'h2E110; cpu_we_in = 1'b1; cpu_data_in = dv[4]; cpu_req_in = 1'b1;
        stall_bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_in); #1;
            if (cpu_ack_o || !ext_we_n_o || ext_addr_o !== 20'h2E10C) stall_bad++;
        end
        n_cmp++; if (stall_bad !== 0) begin n_bad++; $display("FAIL disp_stall: got %0d active cycles want 0", stall_bad); end
        disp_ready_in = 1'b1;
        @(posedge clk_in); #1;
        disp_ready_in = 1'b0;
        mq.push_back({10'd4, dv[4]});
        n_cmp++; if (ext_we_n_o !== 1'b0) begin n_bad++; $display("FAIL disp_unstall: got we_n=%b want 0", ext_we_n_o); end
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            @(posedge clk_in); #1;
            if (cpu_ack_o) lat = c;
        end
        cpu_req_in = 1'b0;
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL disp_5th_ack: got %0d want 2", lat); end
        n_cmp++; if ({disp_valid_o, disp_addr_o, disp_data_o} !== {1'b1, 10'd1, dv[1]}) begin
            n_bad++; $display("FAIL disp_head1: got %b %h %h want 1 001 %h", disp_valid_o, disp_addr_o, disp_data_o, dv[1]); end
        pops0 = n_pops;
        disp_ready_in = 1'b1;
        repeat (8) @(posedge clk_in);
        #1;
        disp_ready_in = 1'b0;
        n_cmp++; if ({n_pops - pops0, 32'(mq.size()), 31'd0, disp_valid_o} !== {32'd4, 32'd0, 32'd0}) begin
            n_bad++; $display("FAIL disp_drain: got pops=%0d left=%0d valid=%b want 4 0 0", n_pops - pops0, mq.size(), disp_valid_o); end
    endtask

    task automatic test_reset_mid();
        int lat, oe, we, doe, bw; logic [15:0] rd; logic er; logic [19:0] ea;
        logic [15:0] d;
        int ack_seen;
        disp_ready_in = 1'b0;
        d = 16'($urandom);
        mq.push_back({10'd1, d});
        run_access(20'h2E104, 1'b1, d, lat, oe, we, doe, bw, rd, er, ea);
        n_cmp++; if ({lat, 31'd0, disp_valid_o} !== {32'd3, 32'd1}) begin
            n_bad++; $display("FAIL rstmid_prime: got lat=%0d valid=%b want 3 1", lat, disp_valid_o); end
        ext_data_in = 16'h7777;
        @(posedge clk_in); #1;
        cpu_addr_in = 20'h30010; cpu_we_in = 1'b0; cpu_req_in = 1'b1;
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        n_cmp++; if (ext_oe_n_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_oe_before: got %b want 0", ext_oe_n_o); end
        reset_n_in = 1'b0;
        #1;
        mq.delete();
        n_cmp++; if ({ext_oe_n_o, ext_we_n_o, ext_data_oe_o, cpu_ack_o, disp_valid_o} !== 5'b11000) begin
            n_bad++; $display("FAIL rstmid_abort: got %b want 11000", {ext_oe_n_o, ext_we_n_o, ext_data_oe_o, cpu_ack_o, disp_valid_o}); end
        cpu_req_in = 1'b0;
        ack_seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_in); #1;
            if (cpu_ack_o) ack_seen++;
        end
        n_cmp++; if (ack_seen !== 0) begin n_bad++; $display("FAIL rstmid_no_ack: got %0d acks want 0", ack_seen); end
        reset_n_in = 1'b1;
        ext_data_in = 16'h5A5A;
        run_access(20'h30010, 1'b0, 16'h0, lat, oe, we, doe, bw, rd, er, ea);
        n_cmp++; if ({lat, oe, 16'h0, rd} !== {32'd5, 32'd4, 16'h0, 16'h5A5A}) begin
            n_bad++; $display("FAIL rstmid_after: got lat=%0d oe=%0d d=%h want 5 4 5a5a", lat, oe, rd); end
        last_rd = 16'h5A5A;
    endtask

    task automatic test_random();
        int lat, oe, we, doe, bw; logic [15:0] rd; logic er; logic [19:0] ea;
        int r, kind, e_lat, e_oe, e_we;
        logic w; logic [15:0] d; logic [19:0] a; logic [15:0] e_rd; bit ext;
        disp_ready_in = 1'b1;
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0: a = 20'($urandom_range(0, 32'h1FFFF));
                1: a = 20'($urandom_range(32'h30000, 32'h37FFF));
                2: a = 20'($urandom_range(32'h38000, 32'h4FFFF));
                3: a = ($urandom_range(0, 1) == 1) ? 20'($urandom_range(32'h50000, 32'hFFFFF))
                                                    : 20'($urandom_range(32'h20000, 32'h2E0FF));
                4: a = 20'(32'h2E100 + 4 * $urandom_range(0, 23));
                default: a = 20'($urandom_range(32'h2E0F0, 32'h2E16F));
            endcase
            w = 1'($urandom_range(0, 1));
            d = 16'($urandom);
            int_data_in = 16'($urandom);
            ext_data_in = 16'($urandom);
            r = model_region(32'(a));
            ext = (r >= 0) && !m_int[r];
            e_lat = (r < 0) ? 1 : m_wait[r] + 2;
            e_oe  = (ext && !w) ? m_wait[r] + 1 : 0;
            e_we  = (ext && w) ? m_wait[r] + 1 : 0;
            if (w) e_rd = last_rd;
            else if (r < 0) e_rd = 16'hFFFF;
            else e_rd = m_int[r] ? int_data_in : ext_data_in;
            if (w && r >= 0 && m_disp[r]) mq.push_back({10'((32'(a) - m_base[r]) >> 2), d});
            run_access(a, w, d, lat, oe, we, doe, bw, rd, er, ea);
            last_rd = e_rd;
            n_cmp++; if (lat !== e_lat) begin n_bad++; $display("FAIL rnd_lat[%0d] a=%h: got %0d want %0d", it, a, lat, e_lat); end
            n_cmp++; if ({er, rd} !== {(r < 0), e_rd}) begin n_bad++; $display("FAIL rnd_resp[%0d] a=%h: got %b %h want %b %h", it, a, er, rd, (r < 0), e_rd); end
            n_cmp++; if ({oe, we, doe, bw} !== {e_oe, e_we, e_we, 32'd0}) begin
                n_bad++; $display("FAIL rnd_strobes[%0d] a=%h: got %0d %0d %0d %0d want %0d %0d %0d 0", it, a, oe, we, doe, bw, e_oe, e_we, e_we); end
            if (ext) begin
                n_cmp++; if (ea !== a) begin n_bad++; $display("FAIL rnd_addr[%0d]: got %h want %h", it, ea, a); end
            end
            @(posedge clk_in); #1;
            n_cmp++; if (cpu_ack_o !== 1'b0) begin n_bad++; $display("FAIL rnd_ack_pulse[%0d]: got %b want 0", it, cpu_ack_o); end
        end
        repeat (3) @(posedge clk_in);
        #1;
        disp_ready_in = 1'b0;
        n_cmp++; if (mq.size() !== 0) begin n_bad++; $display("FAIL rnd_disp_left: got %0d want 0", mq.size()); end
    endtask

    initial begin
        test_reset();
        test_int_read();
        test_ext_read();
        test_ext_write();
        test_unmapped();
        test_disp_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/saturn_bus_ctrl.md
Name: saturn_bus_ctrl

Overview:
- Parametrised memory-bus controller between saturn_core and the external 16-bit bus, internal ROM and the display controller.
- Replaces fixed address compares, fixed read mux and the tied-high mem_ack with N decoded regions, each with programmable wait states and a real ack handshake.
- Display-window writes are shadowed into a FIFO feeding the display controller, with backpressure stalling the CPU.

Parameters:
- ADDR_W, 20, address width.
- DATA_W, 16, data width.
- N_REG, 4, number of decoded regions.
- REG_BASE, {N_REG{ADDR_W'h0}}, packed inclusive region base addresses, region i at [i*ADDR_W +: ADDR_W].
- REG_LIMIT, {N_REG{ADDR_W'h0}}, packed exclusive region limits.
- REG_WAIT, {N_REG{4'h0}}, packed per-region wait states, 0..15.
- REG_INT, 'b0, N_REG mask; region served from int_data_in, no external strobes.
- REG_DISP, 'b0, N_REG mask; writes also pushed to the display FIFO.
- DISP_DEPTH, 4, display FIFO depth, power of two, >= 2.

Ports:
- clk_in  in  1  clock.
- reset_n_in  in  1  asynchronous active-low reset.
- cpu_addr_in  in  ADDR_W  access address, held while cpu_req_in is high.
- cpu_req_in  in  1  request; held until cpu_ack_o.
- cpu_we_in  in  1  1 = write.
- cpu_data_in  in  DATA_W  write data.
- cpu_data_o  out  DATA_W  read data, valid with cpu_ack_o.
- cpu_ack_o  out  1  one-cycle completion pulse.
- cpu_err_o  out  1  unmapped access, pulses with cpu_ack_o.
- int_data_in  in  DATA_W  internal ROM data.
- ext_addr_o  out  ADDR_W  latched external address.
- ext_oe_n_o  out  1  external read strobe.
- ext_we_n_o  out  1  external write strobe.
- ext_data_o  out  DATA_W  external write data.
- ext_data_oe_o  out  1  tristate enable for ext_data_o.
- ext_data_in  in  DATA_W  external read data.
- disp_valid_o  out  1  FIFO head valid.
- disp_ready_in  in  1  display controller accepts head.
- disp_addr_o  out  10  head word offset = (addr - REG_BASE[i])[11:2].
- disp_data_o  out  DATA_W  head data.

Behaviour:
- Reset values: cpu_ack_o=0, cpu_err_o=0, cpu_data_o=0, ext_oe_n_o=1, ext_we_n_o=1, ext_data_oe_o=0, ext_addr_o=0, ext_data_o=0, disp_valid_o=0. FSM goes to IDLE, FIFO is emptied, wait counter is cleared.
- Reset mid-operation aborts the access immediately. Strobes deassert asynchronously. No ack is issued.
- Decode: region i hits when REG_BASE[i] <= addr < REG_LIMIT[i]. The lowest index wins on overlap.
- FSM states: IDLE, ACCESS, ACK.
- IDLE, on cpu_req_in:
  - Latch addr, we, data, region and wait count W.
  - Unmapped: go to ACK with data = all ones and err=1.
  - Display write with FIFO full and no pop this cycle: stay in IDLE (stall). Otherwise push {offset, data} and proceed.
  - Go to ACCESS.
- ACCESS lasts W+1 cycles, counted down.
  - External read: ext_oe_n_o=0 throughout.
  - External write: ext_we_n_o=0 and ext_data_oe_o=1 throughout.
  - Internal region: no strobes.
  - On the last cycle, sample ext_data_in or int_data_in into cpu_data_o. Go to ACK.
- ACK: cpu_ack_o=1 for one cycle. Strobes are high. ext_data_oe_o=0. Return to IDLE.
  - A request still high in the following IDLE cycle is treated as a new access.
- Latency: req sampled in cycle 0; ack in cycle W+2. Unmapped access: ack in cycle 1.
- cpu_data_o holds its value until the next read completes.
- Writes do not change cpu_data_o.
- ext_addr_o changes only when IDLE accepts a request.
- FIFO push and pop:
  - Pop when disp_valid_o & disp_ready_in.
  - Push and pop in the same cycle, when full or when not empty, keeps the count unchanged.
  - disp_valid_o is registered from count != 0.
  - Head outputs are stable while valid and not ready.
- Display-region reads behave as normal external reads with no FIFO activity.

Decomposition:
- saturn_bus_pkg holds:
  - state enum {IDLE, ACCESS, ACK}.
  - the WAIT_W=4 constant.
  - a function region_hit(addr, base, limit).
  - a function first_hit(hit_vec) returning index and valid.
- Sub-module saturn_sync_fifo (parametrised WIDTH, DEPTH; async active-low reset; push/pop/full/empty/count) holds the display FIFO.

Test Plan:
- Region 0 = 0x00000-0x20000, REG_INT, wait 0; read 0x00004, int_data_in=16'hA5C3 -> ack in cycle 2, cpu_data_o=A5C3, ext strobes never low.
- Region 1 = 0x30000-0x40000, external, wait 3; read 0x30010, ext_data_in=16'h1234 -> ext_oe_n_o low for exactly 4 cycles, ack in cycle 5, cpu_data_o=1234, ext_addr_o=0x30010.
- Write 16'hBEEF to 0x30020, wait 3 -> ext_we_n_o and ext_data_oe_o active for 4 cycles with ext_data_o=BEEF; cpu_data_o unchanged.
- Region 2 = 0x2E100-0x2E160, REG_DISP, DISP_DEPTH=4, disp_ready_in=0; 5 writes to 0x2E100+4k -> first 4 complete with disp_addr_o=0 at the head; 5th stalls in IDLE; raise disp_ready_in for one cycle -> 5th proceeds; FIFO stays full with no count overflow.
- Read 0xF0000 (unmapped) -> ack and err in cycle 1, cpu_data_o=FFFF, no strobes.
- Assert reset_n_in=0 during cycle 2 of a wait-3 read -> ext_oe_n_o=1 immediately, no ack, FIFO empty; after release a new read completes normally.
